// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between fetch_stage and imem
//   req   master->slave  fetch request
//   addr  master->slave  fetch address, held while req=1 until ready=1
//   ready slave->master  response this cycle, rdata valid
//   rdata slave->master  fetched instruction
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rdata);
  modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC, imem req/ready handshake and IF/ID pipeline register
//   clk, reset            clock, synchronous active-high reset
//   i_pc_write            0 = hold PC (hazard stall)
//   i_if_id_write         0 = hold IF/ID register (hazard stall)
//   i_flush               redirect fetch to i_branch_target, bubble IF/ID
//   i_branch_target       redirect address
//   imem                  fetch_stage_if.master instruction memory bus
//   o_if_id_instr/pc_plus4/valid  IF/ID register to decode
//   o_if_id_rs/rt         instr[25:21]/[20:16] for the hazard detector
//   FETCH_PERF_CNT_EN     adds saturating o_perf_stall_cyc/o_perf_flush_cnt/o_perf_imem_wait
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_pc_write,
  input  logic                i_if_id_write,
  input  logic                i_flush,
  input  logic [31:0]         i_branch_target,
  fetch_stage_if.master       imem,
  output logic [31:0]         o_if_id_instr,
  output logic [31:0]         o_if_id_pc_plus4,
  output logic                o_if_id_valid,
  output logic [4:0]          o_if_id_rs,
  output logic [4:0]          o_if_id_rt
`ifdef FETCH_PERF_CNT_EN
  , output logic [CNT_W-1:0]  o_perf_stall_cyc,
  output logic [CNT_W-1:0]    o_perf_flush_cnt,
  output logic [CNT_W-1:0]    o_perf_imem_wait
`endif
);
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc, r_tgt, w_tgt;
  logic [31:0] r_buf_instr, w_buf_instr, r_buf_pc4, w_buf_pc4;
  logic [31:0] r_instr, w_instr, r_pc4, w_pc4;
  logic        r_valid, w_valid;
  logic        w_adv;
  logic [31:0] w_pc_inc;
  assign w_adv    = i_pc_write & i_if_id_write;
  assign w_pc_inc = r_pc + 32'd4;
  assign imem.req  = r_state != HOLD;
  assign imem.addr = r_pc;
  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_tgt       = r_tgt;
    w_buf_instr = r_buf_instr;
    w_buf_pc4   = r_buf_pc4;
    // once decode takes the slot and nothing new arrives it becomes a bubble
    w_instr     = i_if_id_write ? 32'h0 : r_instr;
    w_pc4       = i_if_id_write ? 32'h0 : r_pc4;
    w_valid     = i_if_id_write ? 1'b0 : r_valid;
    case (r_state)
      FETCH: begin
        if (i_flush) begin
          w_pc    = imem.ready ? i_branch_target : r_pc;
          w_tgt   = imem.ready ? r_tgt : i_branch_target;
          w_state = imem.ready ? FETCH : DROP;
        end else if (imem.ready && w_adv) begin
          w_instr = imem.rdata;
          w_pc4   = w_pc_inc;
          w_valid = 1'b1;
          w_pc    = w_pc_inc;
        end else if (imem.ready) begin
          w_buf_instr = imem.rdata;
          w_buf_pc4   = w_pc_inc;
          w_state     = HOLD;
        end
      end
      HOLD: begin
        if (i_flush) begin
          w_pc    = i_branch_target;
          w_state = FETCH;
        end else if (w_adv) begin
          w_instr = r_buf_instr;
          w_pc4   = r_buf_pc4;
          w_valid = 1'b1;
          w_pc    = w_pc_inc;
          w_state = FETCH;
        end
      end
      DROP: begin
        // the in-flight response is discarded; the newest flush target wins
        w_tgt = i_flush ? i_branch_target : r_tgt;
        if (imem.ready) begin
          w_pc    = i_flush ? i_branch_target : r_tgt;
          w_state = FETCH;
        end
      end
      default: w_state = FETCH;
    endcase
    if (i_flush) begin
      w_instr = 32'h0;
      w_pc4   = 32'h0;
      w_valid = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_tgt       <= 32'h0;
      r_buf_instr <= 32'h0;
      r_buf_pc4   <= 32'h0;
      r_instr     <= 32'h0;
      r_pc4       <= 32'h0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_tgt       <= w_tgt;
      r_buf_instr <= w_buf_instr;
      r_buf_pc4   <= w_buf_pc4;
      r_instr     <= w_instr;
      r_pc4       <= w_pc4;
      r_valid     <= w_valid;
    end
  end
  assign o_if_id_instr    = r_instr;
  assign o_if_id_pc_plus4 = r_pc4;
  assign o_if_id_valid    = r_valid;
  assign o_if_id_rs       = r_instr[25:21];
  assign o_if_id_rt       = r_instr[20:16];
`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cyc, r_flush_cnt, r_imem_wait;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
      r_imem_wait <= '0;
    end else begin
      if (!i_if_id_write && !(&r_stall_cyc)) r_stall_cyc <= r_stall_cyc + 1'b1;
      if (i_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (imem.req && !imem.ready && !(&r_imem_wait)) r_imem_wait <= r_imem_wait + 1'b1;
    end
  end
  assign o_perf_stall_cyc = r_stall_cyc;
  assign o_perf_flush_cnt = r_flush_cnt;
  assign o_perf_imem_wait = r_imem_wait;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven and scoreboard checks of fetch_stage against a wait-state imem model
module tb_fetch_stage;
  logic clk, reset, pcw, ifw, flush;
  logic [31:0] tgt;
  int ws;
  logic [31:0] o_instr, o_pc4, u2_instr, u2_pc4;
  logic o_valid, u2_valid;
  logic [4:0] o_rs, o_rt, u2_rs, u2_rt;
  int n_tests = 0, n_fail = 0;
  fetch_stage_if bus();
  fetch_stage_if bus2();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] p_stall, p_flush, p_wait, p2_stall, p2_flush, p2_wait;
`endif
  fetch_stage dut (
    .clk(clk), .reset(reset), .i_pc_write(pcw), .i_if_id_write(ifw), .i_flush(flush),
    .i_branch_target(tgt), .imem(bus.master), .o_if_id_instr(o_instr), .o_if_id_pc_plus4(o_pc4),
    .o_if_id_valid(o_valid), .o_if_id_rs(o_rs), .o_if_id_rt(o_rt)
`ifdef FETCH_PERF_CNT_EN
    , .o_perf_stall_cyc(p_stall), .o_perf_flush_cnt(p_flush), .o_perf_imem_wait(p_wait)
`endif
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u2 (
    .clk(clk), .reset(reset), .i_pc_write(pcw), .i_if_id_write(ifw), .i_flush(flush),
    .i_branch_target(tgt), .imem(bus2.master), .o_if_id_instr(u2_instr), .o_if_id_pc_plus4(u2_pc4),
    .o_if_id_valid(u2_valid), .o_if_id_rs(u2_rs), .o_if_id_rt(u2_rt)
`ifdef FETCH_PERF_CNT_EN
    , .o_perf_stall_cyc(p2_stall), .o_perf_flush_cnt(p2_flush), .o_perf_imem_wait(p2_wait)
`endif
  );
  assign bus2.ready = 1'b1;
  assign bus2.rdata = 32'h0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h8D2A_0000 + a;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // imem model: ready after ws waiting cycles of one request
  int cnt = 0;
  always @(negedge clk) begin
    #1;
    if (reset || !bus.req) begin
      cnt = 0;
      bus.ready = 1'b0;
    end else begin
      if (bus.ready) cnt = 0;
      bus.ready = (cnt == ws);
      if (!bus.ready) cnt++;
    end
    bus.rdata = instr_of(bus.addr);
  end

  // scoreboard: push on accepted response, pop when decode consumes IF/ID
  typedef struct {logic [31:0] instr; logic [31:0] pc4;} exp_t;
  exp_t q[$];
  bit dropping = 0;
  logic prev_req = 0, prev_ready = 0, prev_rst = 1;
  logic [31:0] prev_addr = 0;
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (reset) begin
      q.delete();
      dropping = 0;
    end else begin
      if (bus.req && prev_req && !prev_ready && !prev_rst) check("addr_stable", bus.addr, prev_addr);
      if (o_valid && ifw && !flush) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: got instr %h expected none", o_instr);
        end else begin
          e = q.pop_front();
          check("sb_instr", o_instr, e.instr);
          check("sb_pc4", o_pc4, e.pc4);
          check("sb_rs", {27'b0, o_rs}, {27'b0, e.instr[25:21]});
          check("sb_rt", {27'b0, o_rt}, {27'b0, e.instr[20:16]});
        end
      end
      if (flush) q.delete();
      if (bus.req && bus.ready) begin
        if (flush || dropping) dropping = 0;
        else q.push_back('{instr_of(bus.addr), bus.addr + 32'd4});
      end else if (bus.req && flush) dropping = 1;
    end
    prev_req = bus.req;
    prev_ready = bus.ready;
    prev_rst = reset;
    prev_addr = bus.addr;
  end

  // ctl = {reset, pc_write, if_id_write, flush}; ex = {valid, req}; outputs checked after the edge
  typedef struct {logic [3:0] ctl; logic [31:0] tgt; int ws; logic [1:0] ex; logic [31:0] ea; logic [31:0] ep;} vec_t;
  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] t, input int w,
                              input logic [1:0] x, input logic [31:0] a, input logic [31:0] p);
    vec_t v;
    v.ctl = c; v.tgt = t; v.ws = w; v.ex = x; v.ea = a; v.ep = p;
    return v;
  endfunction

  task automatic drive(input logic [3:0] c, input logic [31:0] t, input int w);
    @(negedge clk);
    {reset, pcw, ifw, flush} = c;
    tgt = t;
    ws = w;
  endtask

  vec_t tv[37];
  initial begin
    reset = 1; pcw = 1; ifw = 1; flush = 0; tgt = 0; ws = 0;
    bus.ready = 0; bus.rdata = 0;
    tv[0]  = mk(4'b1110, 0, 0, 2'b01, 0, 0);
    tv[1]  = mk(4'b1110, 0, 0, 2'b01, 0, 0);
    tv[2]  = mk(4'b0110, 0, 0, 2'b11, 4, 4);
    tv[3]  = mk(4'b0110, 0, 0, 2'b11, 8, 8);
    tv[4]  = mk(4'b0110, 0, 0, 2'b11, 12, 12);
    tv[5]  = mk(4'b0110, 0, 0, 2'b11, 16, 16);
    tv[6]  = mk(4'b0110, 0, 2, 2'b01, 16, 0);
    tv[7]  = mk(4'b0110, 0, 2, 2'b01, 16, 0);
    tv[8]  = mk(4'b0110, 0, 2, 2'b11, 20, 20);
    tv[9]  = mk(4'b0110, 0, 2, 2'b01, 20, 0);
    tv[10] = mk(4'b0110, 0, 2, 2'b01, 20, 0);
    tv[11] = mk(4'b0110, 0, 2, 2'b11, 24, 24);
    tv[12] = mk(4'b1110, 0, 0, 2'b01, 0, 0);
    tv[13] = mk(4'b0110, 0, 0, 2'b11, 4, 4);
    tv[14] = mk(4'b0110, 0, 0, 2'b11, 8, 8);
    tv[15] = mk(4'b0110, 0, 0, 2'b11, 12, 12);
    tv[16] = mk(4'b0000, 0, 0, 2'b10, 0, 12);
    tv[17] = mk(4'b0000, 0, 0, 2'b10, 0, 12);
    tv[18] = mk(4'b0110, 0, 0, 2'b11, 16, 16);
    tv[19] = mk(4'b0110, 0, 0, 2'b11, 20, 20);
    tv[20] = mk(4'b0110, 0, 2, 2'b01, 20, 0);
    tv[21] = mk(4'b0111, 32'h100, 2, 2'b01, 20, 0);
    tv[22] = mk(4'b0110, 0, 2, 2'b01, 32'h100, 0);
    tv[23] = mk(4'b0110, 0, 2, 2'b01, 32'h100, 0);
    tv[24] = mk(4'b0110, 0, 2, 2'b01, 32'h100, 0);
    tv[25] = mk(4'b0110, 0, 2, 2'b11, 32'h104, 32'h104);
    tv[26] = mk(4'b0101, 32'h200, 0, 2'b01, 32'h200, 0);
    tv[27] = mk(4'b0110, 0, 0, 2'b11, 32'h204, 32'h204);
    tv[28] = mk(4'b0100, 0, 0, 2'b10, 0, 32'h204);
    tv[29] = mk(4'b0111, 32'h300, 0, 2'b01, 32'h300, 0);
    tv[30] = mk(4'b0110, 0, 0, 2'b11, 32'h304, 32'h304);
    tv[31] = mk(4'b0110, 0, 3, 2'b01, 32'h304, 0);
    tv[32] = mk(4'b0111, 32'h400, 3, 2'b01, 32'h304, 0);
    tv[33] = mk(4'b0111, 32'h500, 3, 2'b01, 32'h304, 0);
    tv[34] = mk(4'b0110, 0, 3, 2'b01, 32'h500, 0);
    tv[35] = mk(4'b0110, 0, 0, 2'b11, 32'h504, 32'h504);
    tv[36] = mk(4'b1110, 0, 0, 2'b01, 0, 0);
    for (int i = 0; i < 37; i++) begin
      drive(tv[i].ctl, tv[i].tgt, tv[i].ws);
      @(posedge clk);
      #1;
      check($sformatf("r%0d_valid", i), {31'b0, o_valid}, {31'b0, tv[i].ex[1]});
      check($sformatf("r%0d_req", i), {31'b0, bus.req}, {31'b0, tv[i].ex[0]});
      if (tv[i].ex[0]) check($sformatf("r%0d_addr", i), bus.addr, tv[i].ea);
      check($sformatf("r%0d_pc4", i), o_pc4, tv[i].ep);
      check($sformatf("r%0d_instr", i), o_instr, tv[i].ex[1] ? instr_of(tv[i].ep - 32'd4) : 32'h0);
`ifdef FETCH_PERF_CNT_EN
      if (i == 19) begin
        check("perf_stall", p_stall, 32'd2);
        check("perf_flush", p_flush, 32'd0);
      end
`endif
    end
    check("wrap_reset_addr", bus2.addr, 32'hFFFF_FFFC);
    drive(4'b0110, 0, 0);
    @(posedge clk);
    #1;
    check("wrap_addr1", bus2.addr, 32'h0);
    check("wrap_pc4_1", u2_pc4, 32'h0);
    check("wrap_valid", {31'b0, u2_valid}, 32'd1);
    check("main_pc4_after_rst", o_pc4, 32'd4);
    drive(4'b0110, 0, 0);
    @(posedge clk);
    #1;
    check("wrap_addr2", bus2.addr, 32'h4);
    check("wrap_pc4_2", u2_pc4, 32'h4);
    check("main_pc4_next", o_pc4, 32'd8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
